// File: rtl/lector_mascara.sv
// Mask coefficient reader: fetches N*N consecutive words from memory starting
// at a latched base address and streams them out with a row-major index.
module lector_mascara #(
  parameter int BITS_DATO_MEM      = 21,
  parameter int BITS_DIRECCION_MEM = 10,
  parameter int BITS_MASCARA       = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          iniciar,
  input  logic [BITS_DIRECCION_MEM-1:0] direccion_base,
  input  logic [BITS_MASCARA-1:0]       tamano_mascara,
  output logic                          leer_mem,
  output logic [BITS_DIRECCION_MEM-1:0] direccion_mem,
  input  logic [BITS_DATO_MEM-1:0]      datos_mem,
  output logic [BITS_DATO_MEM-1:0]      coeficiente,
  output logic [5:0]                    indice_coeficiente,
  output logic                          coeficiente_valido,
  output logic                          ocupado,
  output logic                          listo
);

  typedef enum logic [1:0] {REPOSO, LEYENDO, ESPERA} estado_t;

  estado_t                       estado;
  logic [BITS_DIRECCION_MEM-1:0] base;
  logic [5:0]                    total, cnt_lect, cnt_coef;
  logic                          dato_vld;   // datos_mem carries a live read this cycle
  logic [5:0]                    n6, total_nuevo;

  assign n6          = 6'(tamano_mascara);
  assign total_nuevo = n6 * n6;

  // Busy spans the read, memory-latency and output-register stages.
  assign ocupado = leer_mem | dato_vld | coeficiente_valido;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado             <= REPOSO;
      base               <= '0;
      total              <= '0;
      cnt_lect           <= '0;
      cnt_coef           <= '0;
      dato_vld           <= 1'b0;
      leer_mem           <= 1'b0;
      direccion_mem      <= '0;
      coeficiente        <= '0;
      indice_coeficiente <= '0;
      coeficiente_valido <= 1'b0;
      listo              <= 1'b0;
    end else begin
      dato_vld           <= leer_mem;
      coeficiente_valido <= 1'b0;
      listo              <= 1'b0;

      if (dato_vld && !iniciar) begin
        coeficiente        <= datos_mem;
        indice_coeficiente <= cnt_coef;
        coeficiente_valido <= 1'b1;
        listo              <= (cnt_coef == total - 6'd1);
        cnt_coef           <= cnt_coef + 6'd1;
      end

      if (iniciar) begin
        // A start in any state restarts; in-flight data is dropped.
        dato_vld <= 1'b0;
        cnt_coef <= '0;
        if (tamano_mascara != '0) begin
          base          <= direccion_base;
          total         <= total_nuevo;
          direccion_mem <= direccion_base;
          leer_mem      <= 1'b1;
          cnt_lect      <= 6'd1;
          estado        <= LEYENDO;
        end else begin
          leer_mem <= 1'b0;
          estado   <= REPOSO;
        end
      end else begin
        case (estado)
          REPOSO: leer_mem <= 1'b0;
          LEYENDO: begin
            if (cnt_lect == total) begin
              leer_mem <= 1'b0;
              estado   <= ESPERA;
            end else begin
              leer_mem      <= 1'b1;
              direccion_mem <= base + BITS_DIRECCION_MEM'(cnt_lect);
              cnt_lect      <= cnt_lect + 6'd1;
            end
          end
          ESPERA: if (listo) estado <= REPOSO;
          default: estado <= REPOSO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lector_mascara.sv
// Directed bench for lector_mascara: a memory model returns word = address,
// and a scoreboard checks every read address and every output coefficient.
module tb_lector_mascara;
  localparam int D = 21, A = 10, M = 3;

  logic         clk = 1'b0, reset, iniciar;
  logic [A-1:0] direccion_base, direccion_mem;
  logic [M-1:0] tamano_mascara;
  logic         leer_mem, coeficiente_valido, ocupado, listo;
  logic [D-1:0] datos_mem, coeficiente;
  logic [5:0]   indice_coeficiente;

  lector_mascara #(.BITS_DATO_MEM(D), .BITS_DIRECCION_MEM(A), .BITS_MASCARA(M)) dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .direccion_base(direccion_base),
    .tamano_mascara(tamano_mascara), .leer_mem(leer_mem), .direccion_mem(direccion_mem),
    .datos_mem(datos_mem), .coeficiente(coeficiente), .indice_coeficiente(indice_coeficiente),
    .coeficiente_valido(coeficiente_valido), .ocupado(ocupado), .listo(listo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [D-1:0] dato;
    logic [5:0]   idx;
    logic         fin;
  } coef_t;

  coef_t        q_co[$];
  logic [A-1:0] q_rd[$];
  int ncmp = 0, nfail = 0, cyc = 0, c0 = 0;
  int occ_cnt = 0, listo_cnt = 0, listo_cyc = -1, first_cyc = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) datos_mem <= leer_mem ? D'(direccion_mem) : '0;

  // Scoreboard side: pop on every DUT read and every valid coefficient.
  always @(negedge clk) begin
    if (!reset) begin
      coef_t e;
      if (ocupado) occ_cnt++;
      if (leer_mem) begin
        if (q_rd.size() == 0) chk("rd_extra", 32'(leer_mem), 32'd0);
        else chk("rd_addr", 32'(direccion_mem), 32'(q_rd.pop_front()));
      end
      if (coeficiente_valido) begin
        if (q_co.size() == 0) chk("co_extra", 32'(coeficiente_valido), 32'd0);
        else begin
          e = q_co.pop_front();
          chk("co_dato", 32'(coeficiente), 32'(e.dato));
          chk("co_idx", 32'(indice_coeficiente), 32'(e.idx));
          chk("co_listo", 32'(listo), 32'(e.fin));
        end
        if (indice_coeficiente == 6'd0) first_cyc = cyc;
      end else if (listo) chk("listo_sin_valido", 32'(listo), 32'd0);
      if (listo) begin
        listo_cnt++;
        listo_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [A-1:0] b, input int n, input int nrd, input int nco);
    logic [A-1:0] a;
    for (int i = 0; i < nrd; i++) begin
      a = b + A'(i);
      q_rd.push_back(a);
    end
    for (int i = 0; i < nco; i++) begin
      coef_t e;
      a = b + A'(i);
      e.dato = D'(a);
      e.idx  = 6'(i);
      e.fin  = (i == n * n - 1);
      q_co.push_back(e);
    end
  endtask

  task automatic start(input logic [A-1:0] b, input logic [M-1:0] n);
    occ_cnt = 0; listo_cnt = 0; listo_cyc = -1; first_cyc = -1;
    direccion_base = b;
    tamano_mascara = n;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    c0 = cyc;
  endtask

  task automatic drain(input string tag);
    int b = 0;
    while ((q_rd.size() != 0 || q_co.size() != 0 || ocupado) && b < 300) begin
      tick();
      b++;
    end
    chk({tag, "_pend"}, 32'(q_rd.size() + q_co.size()), 32'd0);
    chk({tag, "_ocupado"}, 32'(ocupado), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; iniciar = 1'b0; direccion_base = '0; tamano_mascara = '0;
    #2;
    chk("rst_leer", 32'(leer_mem), 32'd0);
    chk("rst_dir", 32'(direccion_mem), 32'd0);
    chk("rst_coef", 32'(coeficiente), 32'd0);
    chk("rst_idx", 32'(indice_coeficiente), 32'd0);
    chk("rst_valido", 32'(coeficiente_valido), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_listo", 32'(listo), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // N=3 from 0x010; inputs change mid-fetch and must be ignored
    push_fetch(10'h010, 3, 9, 9);
    start(10'h010, 3'd3);
    chk("n3_leer_k1", 32'(leer_mem), 32'd1);
    chk("n3_dir_k1", 32'(direccion_mem), 32'h010);
    chk("n3_ocupado_k1", 32'(ocupado), 32'd1);
    direccion_base = 10'h333;
    tamano_mascara = 3'd5;
    drain("n3");
    chk("n3_first_cyc", 32'(first_cyc), 32'(c0 + 2));
    chk("n3_listo_cyc", 32'(listo_cyc), 32'(c0 + 10));
    chk("n3_listo_cnt", 32'(listo_cnt), 32'd1);
    chk("n3_occ_cnt", 32'(occ_cnt), 32'd11);

    // N=2 wrapping through the top of the address space
    push_fetch(10'h3FE, 2, 4, 4);
    start(10'h3FE, 3'd2);
    drain("wrap");
    chk("wrap_listo_cnt", 32'(listo_cnt), 32'd1);

    // N=0 does nothing
    start(10'h050, 3'd0);
    repeat (10) tick();
    chk("n0_occ_cnt", 32'(occ_cnt), 32'd0);
    chk("n0_listo_cnt", 32'(listo_cnt), 32'd0);

    // Abort: restart with base 0x100, N=1 at edge k+5
    push_fetch(10'h010, 3, 5, 3);
    start(10'h010, 3'd3);
    repeat (4) tick();
    push_fetch(10'h100, 1, 1, 1);
    direccion_base = 10'h100;
    tamano_mascara = 3'd1;
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    chk("abort_leer_k6", 32'(leer_mem), 32'd1);
    chk("abort_dir_k6", 32'(direccion_mem), 32'h100);
    chk("abort_valido_k6", 32'(coeficiente_valido), 32'd0);
    drain("abort");
    chk("abort_listo_cnt", 32'(listo_cnt), 32'd1);
    chk("abort_listo_cyc", 32'(listo_cyc), 32'(c0 + 7));

    // Reset asserted in cycle k+4 while reading
    push_fetch(10'h010, 3, 3, 1);
    start(10'h010, 3'd3);
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("mrst_leer", 32'(leer_mem), 32'd0);
    chk("mrst_dir", 32'(direccion_mem), 32'd0);
    chk("mrst_coef", 32'(coeficiente), 32'd0);
    chk("mrst_valido", 32'(coeficiente_valido), 32'd0);
    chk("mrst_ocupado", 32'(ocupado), 32'd0);
    chk("mrst_listo", 32'(listo), 32'd0);
    tick(); tick();
    reset = 1'b0;
    occ_cnt = 0;
    repeat (20) tick();
    chk("mrst_occ_cnt", 32'(occ_cnt), 32'd0);
    chk("mrst_pend", 32'(q_rd.size() + q_co.size()), 32'd0);

    // N=7: 49 reads and coefficients back to back
    push_fetch(10'h200, 7, 49, 49);
    start(10'h200, 3'd7);
    drain("n7");
    chk("n7_listo_cnt", 32'(listo_cnt), 32'd1);
    chk("n7_listo_cyc", 32'(listo_cyc), 32'(c0 + 50));
    chk("n7_occ_cnt", 32'(occ_cnt), 32'd51);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/lector_mascara.md
LECTOR_MASCARA -- requirements
Module: lector_mascara

Interface
REQ-001 Parameter BITS_DATO_MEM, default 21: width of one mask coefficient word in memory.
REQ-002 Parameter BITS_DIRECCION_MEM, default 10: memory address width.
REQ-003 Parameter BITS_MASCARA, default 3: width of mask diagonal value N.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 iniciar  in  1  one-cycle start pulse, driven by the mask-control address-change flag.
REQ-007 direccion_base  in  BITS_DIRECCION_MEM  first memory address of mask data.
REQ-008 tamano_mascara  in  BITS_MASCARA  mask diagonal N; mask holds N*N words.
REQ-009 leer_mem  out  1  memory read strobe.
REQ-010 direccion_mem  out  BITS_DIRECCION_MEM  read address, meaningful while leer_mem=1.
REQ-011 datos_mem  in  BITS_DATO_MEM  read data, valid exactly one cycle after the leer_mem cycle.
REQ-012 coeficiente  out  BITS_DATO_MEM  registered coefficient.
REQ-013 indice_coeficiente  out  6  row-major index of coeficiente, 0..N*N-1.
REQ-014 coeficiente_valido  out  1  coeficiente/indice valid this cycle.
REQ-015 ocupado  out  1  fetch in progress.
REQ-016 listo  out  1  one-cycle pulse coincident with the last coeficiente_valido.

Function
REQ-017 FSM states REPOSO, LEYENDO, ESPERA; ESPERA covers the memory-latency and output-register cycles after the last read.
REQ-018 REPOSO: iniciar=1 with tamano_mascara!=0 -> latch direccion_base, total=N*N (6-bit unsigned, exact, max 49), read counter=0; next state LEYENDO.
REQ-019 REPOSO: iniciar=1 with tamano_mascara=0 -> no reads, no listo, stay REPOSO.
REQ-020 LEYENDO: leer_mem=1 every cycle, direccion_mem=latched base+read counter, modulo 2^BITS_DIRECCION_MEM (wrap 1023->0 for default).
REQ-021 LEYENDO exits to ESPERA after exactly total read cycles; ESPERA returns to REPOSO after the last coefficient is output.
REQ-022 Latency: iniciar sampled at edge k -> first leer_mem in cycle k+1 -> datos_mem in k+2 -> coeficiente_valido, indice 0 in k+3.
REQ-023 Coefficients are output one per cycle, consecutive, no gaps, indices strictly 0,1,...,total-1.
REQ-024 ocupado=1 from the first leer_mem cycle through the last coeficiente_valido cycle inclusive; 0 otherwise.
REQ-025 listo=1 only in the cycle with indice_coeficiente=total-1 and coeficiente_valido=1.
REQ-026 iniciar while ocupado=1 aborts the current fetch: in-flight data discarded (no coeficiente_valido for it), no listo; new fetch follows REQ-018/019 timing from that edge using the new inputs.
REQ-027 direccion_base and tamano_mascara changes outside a sampled iniciar have no effect on an ongoing fetch.
REQ-028 leer_mem=0 and coeficiente_valido=0 in REPOSO; coeficiente holds its last value when not valid.

Reset
REQ-029 reset=1 forces immediately, asynchronously: state REPOSO, leer_mem=0, direccion_mem=0, coeficiente=0, indice_coeficiente=0, coeficiente_valido=0, ocupado=0, listo=0, latched base/total/counters=0.
REQ-030 reset mid-fetch abandons the fetch; after release no read or coefficient occurs until a new iniciar.

Verification
REQ-031 N=3, base=0x010, memory word = address: reads 0x010..0x018 in cycles k+1..k+9; coeficientes 0x010..0x018, indices 0..8, cycles k+3..k+11; listo only in k+11; ocupado high k+1..k+11.
REQ-032 N=2, base=0x3FE: direccion_mem sequence 0x3FE,0x3FF,0x000,0x001; 4 coefficients; listo on index 3.
REQ-033 N=0 with iniciar: leer_mem, coeficiente_valido, ocupado, listo all stay 0.
REQ-034 N=3 fetch, second iniciar (base=0x100, N=1) at edge k+5: at most indices 0..2 from first fetch, no listo for it; read 0x100 in k+6; single coefficient index 0 in k+8 with listo.
REQ-035 Assert reset during LEYENDO at cycle k+4: all outputs 0 in the same cycle; after release 20 idle cycles show no leer_mem or coeficiente_valido.
REQ-036 N=7 back-to-back: 49 consecutive reads, 49 coefficients with indices 0..48, listo exactly once.
